// File: rtl/instr_fetch.sv
// RV32I instruction fetch: PC, credit-limited in-order imem requests, {instr, pc} FIFO toward decode.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned redirects raise fetch_fault and halt fetching.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int UW = CW + 2;

  logic [31:0]   r_pc;
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [31:0]   r_pcq        [DEPTH];
  logic [AW-1:0] r_fifo_wr;
  logic [AW-1:0] r_fifo_rd;
  logic [AW-1:0] r_pcq_wr;
  logic [AW-1:0] r_pcq_rd;
  logic [CW-1:0] r_fifo_cnt;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;
  logic          r_halted;

  logic          w_pop;
  logic [UW-1:0] w_used;
  logic          w_req_fire;
  logic          w_push;
  logic          w_rsp_drop;
  logic          w_misalign;
  logic [31:0]   w_redirect_pc;

  assign w_redirect_pc = redirect_pc & ~32'h0000_0003;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misalign = (redirect_pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // A head leaving this cycle frees its slot for a new request, which is what
  // sustains one instruction per cycle with a 1-cycle memory at DEPTH=2.
  assign w_pop  = (r_fifo_cnt != '0) && out_ready;
  assign w_used = UW'(r_inflight) + UW'(r_fifo_cnt) + UW'(r_drop) - UW'(w_pop);

  assign imem_req_valid = !rst && !redirect_valid && !r_halted && (w_used < UW'(DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_rsp_drop = imem_rsp_valid && (r_drop != '0);
  assign w_push     = imem_rsp_valid && (r_drop == '0) && !redirect_valid;

  assign out_valid   = (r_fifo_cnt != '0);
  assign out_instr   = out_valid ? r_fifo_instr[r_fifo_rd] : '0;
  assign out_pc      = out_valid ? r_fifo_pc[r_fifo_rd]    : '0;
  assign fetch_fault = r_halted;

  // NOTE: storage arrays carry no reset; the pointers and counts that qualify them do.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_pcq[r_pcq_wr] <= r_pc;
    end
    if (w_push) begin
      r_fifo_instr[r_fifo_wr] <= imem_rsp_data;
      r_fifo_pc[r_fifo_wr]    <= r_pcq[r_pcq_rd];
    end
  end

  // NOTE: all state updates are non-blocking so every term above sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_fifo_wr  <= '0;
      r_fifo_rd  <= '0;
      r_pcq_wr   <= '0;
      r_pcq_rd   <= '0;
      r_fifo_cnt <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_halted   <= 1'b0;
    end else if (redirect_valid) begin
      // Everything outstanding now, including a response landing this cycle, is stale.
      r_pc       <= w_redirect_pc;
      r_fifo_wr  <= '0;
      r_fifo_rd  <= '0;
      r_pcq_wr   <= '0;
      r_pcq_rd   <= '0;
      r_fifo_cnt <= '0;
      r_inflight <= '0;
      r_drop     <= r_drop + r_inflight - CW'(imem_rsp_valid);
      r_halted   <= w_misalign;
    end else begin
      if (w_req_fire) begin
        r_pc     <= r_pc + 32'd4;
        r_pcq_wr <= r_pcq_wr + AW'(1);
      end
      if (w_rsp_drop) begin
        r_drop <= r_drop - CW'(1);
      end
      if (w_push) begin
        r_fifo_wr <= r_fifo_wr + AW'(1);
        r_pcq_rd  <= r_pcq_rd + AW'(1);
      end
      if (w_pop) begin
        r_fifo_rd <= r_fifo_rd + AW'(1);
      end
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_push);
      r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an in-order instruction memory model of selectable latency.
// Build with FETCH_ALIGN_CHECK_EN defined to exercise the misaligned-redirect fault path.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // In-order memory: a request accepted in cycle c answers in cycle c + mem_lat.
  logic [31:0] q_addr [$];
  int          q_due  [$];
  int          cyc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_addr.delete();
      q_due.delete();
      cyc = 0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        q_addr.push_back(imem_req_addr);
        q_due.push_back(cyc + mem_lat);
      end
      cyc = cyc + 1;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0, the first cycle with rst low.
  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = rdy;
    imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    tick();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h want 00000000", imem_req_addr); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h want 00000000", out_instr); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h want 00000000", out_pc); end
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    do_reset(1'b1);
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL stream_first_req: got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_addr = 32'(4 * k);
      n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_addr) begin n_fail++; $display("FAIL stream_req c%0d: got v=%b a=%h want v=1 a=%h", k, imem_req_valid, imem_req_addr, exp_addr); end
      if (k < 2) begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_out_early c%0d: got %b want 0", k, out_valid); end
      end else begin
        exp_pc = 32'(4 * (k - 2));
        n_checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== mem_word(exp_pc)) begin n_fail++; $display("FAIL stream_out c%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, out_valid, out_pc, out_instr, exp_pc, mem_word(exp_pc)); end
      end
    end
  endtask

  task automatic test_backpressure();
    int n_req;
    do_reset(1'b0);
    n_req = (imem_req_valid && imem_req_ready) ? 1 : 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (imem_req_valid && imem_req_ready) n_req++;
    end
    n_checks++; if (n_req !== 2) begin n_fail++; $display("FAIL bp_req_count: got %0d want 2", n_req); end
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== mem_word(32'h0)) begin n_fail++; $display("FAIL bp_head: got v=%b pc=%h i=%h want v=1 pc=00000000 i=%h", out_valid, out_pc, out_instr, mem_word(32'h0)); end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL bp_drain0: got %h want 00000000", out_pc); end
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin n_fail++; $display("FAIL bp_resume: got v=%b a=%h want v=1 a=00000008", imem_req_valid, imem_req_addr); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin n_fail++; $display("FAIL bp_drain4: got v=%b pc=%h want v=1 pc=00000004", out_valid, out_pc); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== mem_word(32'h8)) begin n_fail++; $display("FAIL bp_next8: got v=%b pc=%h i=%h want v=1 pc=00000008", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_redirect_flush();
    mem_lat = 2;
    do_reset(1'b1);
    tick();
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_fail++; $display("FAIL rd_second_req: got v=%b a=%h want v=1 a=00000004", imem_req_valid, imem_req_addr); end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rd_no_req_in_redirect: got %b want 0", imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL rd_target_req: got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_req_addr); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_flushed: got %b want 0", out_valid); end
    for (int k = 4; k <= 5; k++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_stale_dropped c%0d: got v=%b pc=%h want v=0", k, out_valid, out_pc); end
    end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== mem_word(32'h100)) begin n_fail++; $display("FAIL rd_first_out: got v=%b pc=%h i=%h want v=1 pc=00000100 i=%h", out_valid, out_pc, out_instr, mem_word(32'h100)); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h104) begin n_fail++; $display("FAIL rd_second_out: got v=%b pc=%h want v=1 pc=00000104", out_valid, out_pc); end
    mem_lat = 1;
  endtask

  task automatic test_pc_wrap();
    do_reset(1'b1);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top_req: got ov=%b v=%b a=%h want ov=0 v=1 a=fffffffc", out_valid, imem_req_valid, imem_req_addr); end
    tick();
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_zero_req: got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_instr !== mem_word(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_out_top: got v=%b pc=%h i=%h want v=1 pc=fffffffc", out_valid, out_pc, out_instr); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_out_zero: got v=%b pc=%h want v=1 pc=00000000", out_valid, out_pc); end
  endtask

  task automatic test_reset_midstream();
    do_reset(1'b0);
    repeat (4) tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_fill: got %b want 1", out_valid); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_now: got ov=%b rv=%b want 0 0", out_valid, imem_req_valid); end
    n_checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL mid_reset_vals: got pc=%h i=%h a=%h want all 0", out_pc, out_instr, imem_req_addr); end
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL mid_restart_req: got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
    repeat (2) tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== mem_word(32'h0)) begin n_fail++; $display("FAIL mid_restart_out: got v=%b pc=%h i=%h want v=1 pc=00000000", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_align();
    do_reset(1'b1);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    #1;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int k = 2; k <= 5; k++) begin
      n_checks++; if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL align_halted c%0d: got f=%b v=%b want f=1 v=0", k, fetch_fault, imem_req_valid); end
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL align_resume: got f=%b v=%b a=%h want f=0 v=1 a=00000200", fetch_fault, imem_req_valid, imem_req_addr); end
`else
    n_checks++; if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL align_ignored: got f=%b v=%b a=%h want f=0 v=1 a=00000100", fetch_fault, imem_req_valid, imem_req_addr); end
    repeat (2) tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL align_out: got v=%b pc=%h f=%b want v=1 pc=00000100 f=0", out_valid, out_pc, fetch_fault); end
`endif
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_pc_wrap();
    test_reset_midstream();
    test_align();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
